// File: rtl/l1i_cache.sv
// Direct-mapped, read-only L1 instruction cache. Hits answer combinationally
// in the request cycle; misses fetch a full 256-bit line from the next level.
module l1i_cache #(
  parameter int NUM_SETS = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         l1i_hit,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic {IDLE, FILL} state_e;

  state_e              state_q, state_d;
  logic [31:0]         pmem_addr_q, pmem_addr_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [255:0]        data_q [NUM_SETS];

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [2:0]       word_sel;
  logic             hit;
  logic             fill_we;
  logic             unused_inputs;

  // Writes and byte enables are not supported by an instruction cache.
  assign unused_inputs = ^{mem_write, mem_byte_enable, mem_wdata, mem_address[1:0]};

  assign req_idx  = mem_address[5 +: IDX_W];
  assign req_tag  = mem_address[31 -: TAG_W];
  assign word_sel = mem_address[4:2];
  assign fill_idx = pmem_addr_q[5 +: IDX_W];
  assign fill_tag = pmem_addr_q[31 -: TAG_W];

  assign hit = (state_q == IDLE) && mem_read && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  assign mem_resp     = hit;
  assign l1i_hit      = hit;
  assign mem_rdata    = data_q[req_idx][{word_sel, 5'b0} +: 32];
  assign pmem_read    = (state_q == FILL);
  assign pmem_address = pmem_addr_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pmem_addr_d = pmem_addr_q;
    valid_d     = valid_q;
    fill_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read && !hit) begin
          pmem_addr_d = {req_tag, req_idx, 5'b0};
          state_d     = FILL;
        end
      end
      FILL: begin
        // A PC redirect mid-fill still completes the latched line.
        if (pmem_resp) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q     <= IDLE;
      pmem_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      pmem_addr_q <= pmem_addr_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: tag and data arrays are deliberately left out of reset; the valid
  // bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[fill_idx] <= pmem_rdata;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_l1i_cache.sv
// Directed bench for l1i_cache: hand-sequenced fills plus a vector table for
// single-cycle IDLE behaviour.
module tb_l1i_cache;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         l1i_hit;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int tests_run = 0;
  int tests_failed = 0;

  l1i_cache #(.NUM_SETS(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .l1i_hit         (l1i_hit),
    .pmem_read       (pmem_read),
    .pmem_address    (pmem_address),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        exp_resp;
    logic        exp_hit;
    logic        exp_pread;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  // Advance to just after the next rising edge; inputs change here, checks
  // follow a couple of time units later, well before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full miss/fill/hit sequence: request addr, answer after lat FILL cycles.
  task automatic fill(input string name, input logic [31:0] addr,
                      input logic [31:0] base, input int lat);
    logic [31:0] line_addr;
    line_addr   = {addr[31:5], 5'b0};
    mem_read    = 1'b1;
    mem_address = addr;
    #2;
    check({name, " c0 resp"}, 32'(mem_resp), 32'd0);
    check({name, " c0 hit"},  32'(l1i_hit),  32'd0);
    for (int i = 1; i <= lat; i++) begin
      step();
      #2;
      check({name, " fill pread"}, 32'(pmem_read), 32'd1);
      check({name, " fill paddr"}, pmem_address, line_addr);
      check({name, " fill resp"},  32'(mem_resp),  32'd0);
      if (i == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = make_line(base);
      end
    end
    step();
    pmem_resp = 1'b0;
    #2;
    check({name, " after resp"},  32'(mem_resp),  32'd1);
    check({name, " after hit"},   32'(l1i_hit),   32'd1);
    check({name, " after pread"}, 32'(pmem_read), 32'd0);
    check({name, " after rdata"}, mem_rdata, base + 32'(addr[4:2]));
  endtask

  task automatic apply_vec(input vec_t v);
    step();
    mem_read    = v.rd;
    mem_write   = v.wr;
    mem_address = v.addr;
    #2;
    check({v.name, " resp"},  32'(mem_resp),  32'(v.exp_resp));
    check({v.name, " hit"},   32'(l1i_hit),   32'(v.exp_hit));
    check({v.name, " pread"}, 32'(pmem_read), 32'(v.exp_pread));
    if (v.chk_rdata) check({v.name, " rdata"}, mem_rdata, v.exp_rdata);
  endtask

  initial begin
    vec_t vecs[$];

    for (int k = 1; k < 8; k++)
      vecs.push_back('{$sformatf("seq 0x%02h", 32'h40 + 4*k), 1'b1, 1'b0,
                       32'h40 + 32'(4*k), 1'b1, 1'b1, 1'b0, 1'b1,
                       32'h1000_0000 + 32'(k)});
    vecs.push_back('{"write only", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"idle no req", 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"after write", 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000});
    vecs.push_back('{"word 7 again", 1'b1, 1'b0, 32'h5C, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0007});

    reset_n         = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'hF;
    mem_address     = 32'h0;
    mem_wdata       = 32'hDEAD_BEEF;
    pmem_rdata      = '0;
    pmem_resp       = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset pread", 32'(pmem_read), 32'd0);
    check("reset paddr", pmem_address,  32'd0);
    check("reset resp",  32'(mem_resp),  32'd0);
    step();
    reset_n = 1'b1;

    // Cold miss with 3-cycle fill latency, then the rest of the line.
    step();
    fill("cold 0x40", 32'h40, 32'h1000_0000, 3);
    foreach (vecs[i]) apply_vec(vecs[i]);

    // Conflict on index 2, then refill the original line with new data.
    step();
    fill("conflict 0x240", 32'h240, 32'h2000_0000, 2);
    step();
    fill("refill 0x40", 32'h4C, 32'h3000_0000, 1);

    // Redirect during FILL: latched line completes, then new address misses.
    step();
    mem_address = 32'h100;
    #2;
    check("redir c0 resp", 32'(mem_resp), 32'd0);
    step();
    mem_address = 32'h800;
    #2;
    check("redir c1 paddr", pmem_address, 32'h100);
    step();
    #2;
    check("redir c2 paddr", pmem_address, 32'h100);
    check("redir c2 resp",  32'(mem_resp), 32'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = make_line(32'h4000_0000);
    step();
    pmem_resp = 1'b0;
    #2;
    check("redir idle resp",  32'(mem_resp),  32'd0);
    check("redir idle pread", 32'(pmem_read), 32'd0);
    step();
    #2;
    check("redir 2nd pread", 32'(pmem_read), 32'd1);
    check("redir 2nd paddr", pmem_address,  32'h800);
    pmem_resp  = 1'b1;
    pmem_rdata = make_line(32'h5000_0000);
    step();
    pmem_resp = 1'b0;
    #2;
    check("redir 0x800 rdata", mem_rdata, 32'h5000_0000);
    check("redir 0x800 resp",  32'(mem_resp), 32'd1);
    step();
    mem_address = 32'h104;
    #2;
    check("redir 0x100 hit",   32'(l1i_hit), 32'd1);
    check("redir 0x100 rdata", mem_rdata,    32'h4000_0001);

    // Stray pmem_resp in IDLE must not touch the arrays.
    step();
    mem_read   = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = make_line(32'hBAD0_0000);
    step();
    pmem_resp   = 1'b0;
    mem_read    = 1'b1;
    mem_address = 32'h808;
    #2;
    check("stray 0x800 hit",   32'(l1i_hit),   32'd1);
    check("stray 0x800 rdata", mem_rdata,      32'h5000_0002);
    check("stray pread",       32'(pmem_read), 32'd0);

    // Reset in the middle of a fill.
    step();
    mem_address = 32'h240;
    #2;
    check("rst c0 resp", 32'(mem_resp), 32'd0);
    step();
    #2;
    check("rst c1 pread", 32'(pmem_read), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst async pread", 32'(pmem_read), 32'd0);
    check("rst async paddr", pmem_address,  32'd0);
    step();
    step();
    reset_n = 1'b1;
    fill("post-rst 0x40", 32'h40, 32'h6000_0000, 2);
    step();
    mem_address = 32'h100;
    #2;
    check("post-rst 0x100 resp", 32'(mem_resp), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l1i_cache.md
# l1i_cache

Direct-mapped, read-only L1 instruction cache between the pipeline's instruction port (cmem port a) and the next memory level. It answers fetch hits combinationally in the request cycle, so the fetch stage does not stall. On a miss it fetches a full 256-bit line through a read handshake, fills it, and then answers the pending fetch. It also drives the `l1i_hit` indication consumed by the pipeline performance counters.

## Interface
- `NUM_SETS`, default 16: number of lines; power of two, minimum 2. Index = addr[4+log2(NUM_SETS):5].
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: fetch request; the pipeline holds it high continuously.
- `mem_write` in 1: write request; unsupported and ignored (never responded).
- `mem_byte_enable` in 4: ignored; a fetch always returns a full word.
- `mem_address` in 32: fetch byte address; bits [1:0] ignored.
- `mem_wdata` in 32: ignored.
- `mem_rdata` out 32: fetched word.
- `mem_resp` out 1: fetch complete this cycle.
- `l1i_hit` out 1: request served from a valid line this cycle.
- `pmem_read` out 1: line-fill request to the next level.
- `pmem_address` out 32: line address, {tag, index, 5'b0}.
- `pmem_rdata` in 256: fill data, byte 0 in bits [7:0].
- `pmem_resp` in 1: fill data valid; one-cycle pulse.

## Operation
- Storage, all flop-based with asynchronous read:
  - per-line `valid` bit;
  - per-line tag = addr[31:5+log2(NUM_SETS)];
  - per-line 256-bit data.
- Word select = addr[4:2]. The word is taken from data bits [32*sel+31 : 32*sel].
- FSM states: IDLE and FILL.
- IDLE behaviour:
  - Hit condition: mem_read && valid[idx] && tag[idx]==addr tag.
  - On a hit: mem_resp=1, l1i_hit=1, mem_rdata = selected word, all combinationally in the same cycle.
  - On a miss with mem_read=1: latch the line address into `pmem_address` and go to FILL. mem_resp=0.
- FILL behaviour:
  - pmem_read=1 and pmem_address stays constant until pmem_resp.
  - On pmem_resp: write pmem_rdata into data[latched idx], write the latched tag, set valid, return to IDLE.
  - mem_resp=0 and l1i_hit=0 throughout FILL.
- Address change during FILL (the pipeline redirects the PC on a taken branch): the fill completes for the latched line. IDLE then re-evaluates the new address, which may miss again.
- mem_read dropping during FILL does not abort the fill.
- pmem_resp received in IDLE is ignored; no array write occurs.
- mem_write=1: no response and no state change. The block never asserts any write toward the next level.
- mem_rdata when mem_resp=0: don't-care. The implementation drives the selected word of the indexed line regardless.

## Timing
- Reset (asynchronous on reset_n low):
  - state = IDLE, all valid bits = 0, pmem_read = 0, pmem_address = 0.
  - mem_resp and l1i_hit evaluate to 0, because no line is valid.
  - Tag and data arrays are not reset.
- Hit latency: 0 cycles; mem_resp is in the request cycle.
- Miss latency, from the first cycle mem_read is seen as a miss in IDLE:
  - cycle 0: miss detected, FILL entered at the next edge;
  - cycles 1..N: pmem_read=1, with pmem_resp arriving in cycle N;
  - cycle N+1: IDLE, the line is valid, so hit and mem_resp=1.
  - Total: pmem latency + 2 cycles.
- Reset asserted during FILL: pmem_read drops immediately and asynchronously; no partial line is written; valid stays 0.
- Fill and hit never coincide: the array write and the hit lookup are in different states, so there is no write-through bypass.

## Test plan
- Reset, then mem_read=1 at 0x0000_0040 → mem_resp=0 and l1i_hit=0 in cycle 0; pmem_read=1 with pmem_address=0x0000_0040 from cycle 1.
- Cold miss with fill data word k = 0x1000_0000+k and pmem_resp after 3 cycles → in the cycle after pmem_resp, mem_resp=1 and mem_rdata=0x1000_0000.
  - Then addresses 0x44..0x5C, one per cycle → mem_resp=1 every cycle, rdata 0x1000_0001..0x1000_0007, pmem_read stays 0.
- Conflict: fill 0x0000_0040, then request 0x0000_0240 (same index, NUM_SETS=16) → miss, pmem_address=0x0000_0240.
  - Then re-request 0x0000_0040 → miss again; data reflects the newest fill.
- Redirect during FILL: miss on 0x0000_0100, then change address to 0x0000_0800 before pmem_resp → pmem_address stays 0x0000_0100 until resp.
  - Next, a fill starts for 0x0000_0800.
  - A later request to 0x0000_0100 hits.
- Assert reset_n=0 mid-FILL, then release → pmem_read=0 immediately and the previously valid 0x0000_0040 misses.
  - A stray pmem_resp in IDLE causes no change.
- mem_write=1 with mem_read=0 at 0x0000_0040 → mem_resp=0, pmem_read=0, cache contents unchanged.
